// File: rtl/program_loader_pkg.sv
// Shared CPU-side definitions: default instruction/address geometry, the
// loader frame start byte and the loader state encoding.
package program_loader_pkg;

    localparam int unsigned INST_W = 13;
    localparam int unsigned ADDR_W = 8;
    localparam logic [7:0]  HEADER = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } load_state_e;

endpackage

// File: rtl/program_loader.sv
// Byte-stream program loader: parses HEADER, N, N two-byte words and an XOR
// checksum, writing each word to instruction memory while holding the CPU.
module program_loader #(
    parameter int unsigned INST_W = program_loader_pkg::INST_W,
    parameter int unsigned ADDR_W = program_loader_pkg::ADDR_W,
    parameter logic [7:0]  HEADER = program_loader_pkg::HEADER
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [INST_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);
    import program_loader_pkg::*;

    // High byte may only carry the INST_W-8 bits that fit into the word.
    function automatic logic hi_ok(input logic [7:0] hi);
        return (hi >> (INST_W - 8)) == 8'd0;
    endfunction

    function automatic logic [INST_W-1:0] assemble(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[INST_W-9:0], lo};
    endfunction

    load_state_e       state_q, state_d;
    logic [7:0]        cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [7:0]        hi_q,    hi_d;
    logic [7:0]        lo_q,    lo_d;
    logic [7:0]        csum_q,  csum_d;
    logic              accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            csum_q  <= csum_d;
        end
    end

    assign rx_ready  = !(state_q == ST_WRITE || state_q == ST_DONE);
    assign accept    = rx_valid && rx_ready;
    assign mem_we    = (state_q == ST_WRITE);
    assign mem_addr  = addr_q;
    assign mem_wdata = assemble(hi_q, lo_q);
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERR);
    assign cpu_hold  = (state_q == ST_COUNT) || (state_q == ST_HI) || (state_q == ST_LO) ||
                       (state_q == ST_WRITE) || (state_q == ST_CHECK);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        csum_d  = csum_q;
        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (accept && rx_data == HEADER) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (accept) begin
                    if (rx_data == 8'd0) begin
                        state_d = ST_ERR;
                    end else begin
                        cnt_d   = rx_data;
                        addr_d  = '0;
                        csum_d  = rx_data;
                        state_d = ST_HI;
                    end
                end
            end
            ST_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_LO;
                end
            end
            ST_LO: begin
                // A bad high byte is only acted on once the pair is complete.
                if (accept) begin
                    lo_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = hi_ok(hi_q) ? ST_WRITE : ST_ERR;
                end
            end
            ST_WRITE: begin
                cnt_d   = cnt_q - 8'd1;
                addr_d  = addr_q + ADDR_W'(1);
                state_d = (cnt_q == 8'd1) ? ST_CHECK : ST_HI;
            end
            ST_CHECK: begin
                if (accept) state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized frame bench for program_loader with a byte-level frame parser
// as reference model.
module tb_program_loader;
    localparam int INST_W = 13;
    localparam int ADDR_W = 8;

    typedef logic [7:0] bq_t[$];

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [INST_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    int exp_addr[$];
    int exp_data[$];

    program_loader dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Write/done monitor
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_addr.size() == 0) begin
                check("we_unexpected", 32'(mem_we), 32'd0);
            end else begin
                check("we_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
                check("we_data", 32'(mem_wdata), 32'(exp_data.pop_front()));
                check("we_hold", 32'(cpu_hold), 32'd1);
            end
        end
        if (mem_we || done) check("rdy_busy", 32'(rx_ready), 32'd0);
        if (done) begin
            done_cnt++;
            check("done_hold", 32'(cpu_hold), 32'd0);
        end
    end

    // Parse a frame as the loader should: queue expected writes, report
    // success and how many bytes the loader consumes before it stops.
    task automatic model_frame(input bq_t f, output bit ok, output int used);
        int n;
        int hi;
        int lo;
        int cs;
        used = 2;
        ok   = 1'b0;
        n    = int'(f[1]);
        if (n == 0) return;
        cs = n;
        for (int w = 0; w < n; w++) begin
            hi = int'(f[2 + 2*w]);
            lo = int'(f[3 + 2*w]);
            used += 2;
            cs = cs ^ hi ^ lo;
            if (hi >= (1 << (INST_W - 8))) return;
            exp_addr.push_back(w);
            exp_data.push_back(hi * 256 + lo);
        end
        used += 1;
        ok = (int'(f[2 + 2*n]) == cs);
    endtask

    function automatic logic [7:0] garbage();
        logic [7:0] g;
        do g = 8'($urandom_range(0, 255)); while (g == 8'hA5);
        return g;
    endfunction

    task automatic make_frame(input int kind, output bq_t f);
        int n;
        int bw;
        logic [7:0] hi;
        logic [7:0] lo;
        logic [7:0] cs;
        f = {};
        f.push_back(8'hA5);
        if (kind == 3) begin
            f.push_back(8'h00);
            return;
        end
        n  = $urandom_range(1, 6);
        bw = $urandom_range(0, n - 1);
        f.push_back(8'(n));
        cs = 8'(n);
        for (int w = 0; w < n; w++) begin
            hi = 8'($urandom_range(0, 31));
            if (kind == 1 && w == bw) hi = 8'($urandom_range(32, 255));
            lo = 8'($urandom_range(0, 255));
            f.push_back(hi);
            f.push_back(lo);
            cs = cs ^ hi ^ lo;
        end
        if (kind == 2) cs = cs ^ 8'($urandom_range(1, 255));
        f.push_back(cs);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rdy_accept", 32'(rx_ready), 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom_range(0, 255));
        @(negedge clk);
    endtask

    task automatic run_frame(input bq_t f);
        bit ok;
        int used;
        model_frame(f, ok, used);
        repeat ($urandom_range(0, 3)) send_byte(garbage());
        for (int i = 0; i < used; i++) begin
            send_byte(f[i]);
            if (i == 0) check("hold_hdr", 32'(cpu_hold), 32'd1);
        end
        if (ok) exp_done++;
        repeat (3) @(negedge clk);
        #1;
        check("done_count", 32'(done_cnt), 32'(exp_done));
        check("error_flag", 32'(error), 32'(!ok));
        check("hold_end", 32'(cpu_hold), 32'd0);
        check("writes_left", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},  32'(rx_ready),  32'd1);
        check({tag, "_we"},   32'(mem_we),    32'd0);
        check({tag, "_addr"}, 32'(mem_addr),  32'd0);
        check({tag, "_data"}, 32'(mem_wdata), 32'd0);
        check({tag, "_hold"}, 32'(cpu_hold),  32'd0);
        check({tag, "_done"}, 32'(done),      32'd0);
        check({tag, "_err"},  32'(error),     32'd0);
    endtask

    initial begin
        bq_t f;
        bit ok;
        int used;
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed frames
        run_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h45, 8'h65});
        run_frame('{8'hA5, 8'h00});
        run_frame('{8'hA5, 8'h01, 8'h20, 8'h00});
        run_frame('{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h45, 8'h65});
        run_frame('{8'hA5, 8'h01, 8'h00, 8'h07, 8'h00});

        // Reset during the LO byte of word 1
        f = '{8'hA5, 8'h02, 8'h01, 8'h23, 8'h00, 8'h45, 8'h65};
        model_frame(f, ok, used);
        for (int i = 0; i < 5; i++) send_byte(f[i]);
        rx_data  = f[5];
        rx_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        check("midrst_writes", 32'(exp_addr.size()), 32'd1);
        exp_addr.delete();
        exp_data.delete();
        rx_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_frame(f);

        // Randomized frames
        for (int k = 0; k < 25; k++) begin
            int r;
            int kind;
            r = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : (r - 6) + 1;
            make_frame(kind, f);
            run_frame(f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
